nvram_upload: RTL and testbench

Reads a window of game work RAM back to the HPS over the ioctl upload channel. This is the reverse of the ROM download path, used to save high-score and NVRAM contents. It sits between hps_io (ioctl upload side) and the core's work-RAM arbiter port. RAM is fetched only during vertical blank, with a one-byte prefetch buffer so sequential reads normally complete without stalling the HPS. A trailing checksum byte is appended after the RAM window.

---
 rtl/nvram_upload.sv | 170 +++++++++++++++++
 tb/tb_nvram_upload.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nvram_upload.sv
// Streams a window of work RAM plus a trailing checksum byte to the HPS ioctl upload channel.
// RAM is fetched only in vblank; a one-byte prefetch buffer lets sequential reads return without a stall.
module nvram_upload #(
    parameter int          ADDR_W = 11,
    parameter logic [7:0]  INDEX  = 8'd4,
    parameter int          BASE   = 0
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    input  logic              vblank,
    output logic              ram_req,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_dout,
    input  logic              ram_ack
);

    localparam logic [24:0]       LEN    = 25'(2**ADDR_W);
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);

    typedef enum logic [1:0] {IDLE, WAIT_VB, REQ} state_t;

    state_t              state_q;
    logic                active_q, rd_q, ram_req_q, wait_q;
    logic                buf_vld_q, demand_q, redo_q, drop_q;
    logic [ADDR_W-1:0]   ram_addr_q, buf_addr_q, redo_addr_q;
    logic [7:0]          din_q, buf_data_q, sum_q;

    logic                active, rd_ok, is_data, is_csum, ack_hit, hit, rd_last, buf_last;
    logic [ADDR_W-1:0]   rd_idx, rd_next_d, buf_next_d;
    logic [7:0]          hit_dat;

    assign active     = ioctl_upload && (ioctl_index == INDEX);
    assign rd_ok      = active && active_q && ioctl_rd && !wait_q && !rd_q;
    assign is_data    = ioctl_addr < LEN;
    assign is_csum    = ioctl_addr == LEN;
    assign rd_idx     = ioctl_addr[ADDR_W-1:0];
    assign rd_next_d  = rd_idx + 1'b1;
    assign rd_last    = &rd_idx;
    assign buf_next_d = buf_addr_q + 1'b1;
    assign buf_last   = &buf_addr_q;
    // A prefetch landing in the same cycle as a read of its address is served straight from the bus.
    assign ack_hit    = (state_q == REQ) && ram_ack && !drop_q && (buf_addr_q == rd_idx);
    assign hit        = (buf_vld_q && (buf_addr_q == rd_idx)) || ack_hit;
    assign hit_dat    = ack_hit ? ram_dout : buf_data_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= IDLE;
            active_q    <= 1'b0;
            rd_q        <= 1'b0;
            ram_req_q   <= 1'b0;
            wait_q      <= 1'b0;
            buf_vld_q   <= 1'b0;
            demand_q    <= 1'b0;
            redo_q      <= 1'b0;
            drop_q      <= 1'b0;
            ram_addr_q  <= '0;
            buf_addr_q  <= '0;
            redo_addr_q <= '0;
            din_q       <= 8'h00;
            buf_data_q  <= 8'h00;
            sum_q       <= 8'h00;
        end else begin
            active_q <= active;
            rd_q     <= ioctl_rd;
            if (active && !active_q) begin
                sum_q     <= 8'h00;
                buf_vld_q <= 1'b0;
            end

            case (state_q)
                IDLE: ;
                WAIT_VB: begin
                    if (!active) begin
                        state_q <= IDLE;
                    end else if (vblank) begin
                        state_q   <= REQ;
                        ram_req_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (ram_ack) begin
                        ram_req_q <= 1'b0;
                        state_q   <= IDLE;
                        drop_q    <= 1'b0;
                        if (active && redo_q) begin
                            redo_q     <= 1'b0;
                            demand_q   <= 1'b1;
                            state_q    <= WAIT_VB;
                            buf_addr_q <= redo_addr_q;
                            ram_addr_q <= BASE_A + redo_addr_q;
                        end else if (active && !drop_q) begin
                            buf_data_q <= ram_dout;
                            buf_vld_q  <= 1'b1;
                            if (demand_q) begin
                                demand_q <= 1'b0;
                                wait_q   <= 1'b0;
                                din_q    <= ram_dout;
                                sum_q    <= sum_q + ram_dout;
                                if (!buf_last) begin
                                    state_q    <= WAIT_VB;
                                    buf_addr_q <= buf_next_d;
                                    ram_addr_q <= BASE_A + buf_next_d;
                                    buf_vld_q  <= 1'b0;
                                end
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (!active) begin
                // The arbiter handshake is never broken; an in-flight result is just thrown away.
                wait_q   <= 1'b0;
                demand_q <= 1'b0;
                redo_q   <= 1'b0;
                drop_q   <= (state_q == REQ) && !ram_ack;
            end else if (rd_ok) begin
                if (!is_data) begin
                    din_q <= is_csum ? (8'h00 - sum_q) : 8'hFF;
                end else if (hit) begin
                    din_q <= hit_dat;
                    sum_q <= sum_q + hit_dat;
                    if (!rd_last) begin
                        state_q    <= WAIT_VB;
                        ram_req_q  <= 1'b0;
                        demand_q   <= 1'b0;
                        buf_addr_q <= rd_next_d;
                        ram_addr_q <= BASE_A + rd_next_d;
                        buf_vld_q  <= 1'b0;
                    end
                end else begin
                    wait_q <= 1'b1;
                    if (state_q == REQ && !ram_ack) begin
                        if (buf_addr_q == rd_idx && !drop_q) begin
                            demand_q <= 1'b1;
                        end else begin
                            redo_q      <= 1'b1;
                            redo_addr_q <= rd_idx;
                        end
                    end else if (state_q == WAIT_VB) begin
                        demand_q   <= 1'b1;
                        buf_addr_q <= rd_idx;
                        ram_addr_q <= BASE_A + rd_idx;
                    end else begin
                        state_q    <= WAIT_VB;
                        ram_req_q  <= 1'b0;
                        demand_q   <= 1'b1;
                        buf_addr_q <= rd_idx;
                        ram_addr_q <= BASE_A + rd_idx;
                        buf_vld_q  <= 1'b0;
                    end
                end
            end
        end
    end

    assign ioctl_din  = din_q;
    assign ioctl_wait = wait_q;
    assign ram_req    = ram_req_q;
    assign ram_addr   = ram_addr_q;

endmodule

// File: tb/tb_nvram_upload.sv
// Scoreboarded bench for nvram_upload: RAM model with programmable ack delay, byte-level reference model.
module tb_nvram_upload;

    localparam int          ADDR_W = 11;
    localparam int          LEN    = 2**ADDR_W;
    localparam int          BASE   = 16;
    localparam logic [7:0]  INDEX  = 8'd4;

    logic              clk_sys, reset, ioctl_upload, ioctl_rd, ioctl_wait, vblank;
    logic              ram_req, ram_ack;
    logic [7:0]        ioctl_index, ioctl_din, ram_dout;
    logic [24:0]       ioctl_addr;
    logic [ADDR_W-1:0] ram_addr;

    nvram_upload #(.ADDR_W(ADDR_W), .INDEX(INDEX), .BASE(BASE)) dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
        .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
        .vblank(vblank), .ram_req(ram_req), .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_ack(ram_ack)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic [7:0] mem [0:LEN-1];
    logic [7:0] exp_q [$];
    logic [7:0] msum;
    int checks = 0, errors = 0;
    int stall_cnt = 0, ack_cnt = 0, ack_dly = 0;
    bit rand_mode = 0;

    // Reference: data bytes come from RAM at BASE+addr, the byte at LEN cancels the running sum.
    function automatic logic [7:0] model_rd(input int a);
        logic [7:0] d;
        if (a < LEN) begin
            d = mem[(BASE + a) % LEN];
            msum = msum + d;
        end else if (a == LEN) begin
            d = 8'h00 - msum;
        end else begin
            d = 8'hFF;
        end
        return d;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, expv);
        end
    endtask

    // Arbiter / RAM model.
    initial begin
        ram_ack  = 1'b0;
        ram_dout = 8'h00;
        forever begin
            @(posedge clk_sys); #1;
            if (ram_req) begin
                int d;
                bit ab;
                d  = rand_mode ? int'($urandom_range(0, 3)) : ack_dly;
                ab = 1'b0;
                for (int k = 0; k < d; k++) begin
                    @(posedge clk_sys); #1;
                    if (!ram_req) begin
                        ab = 1'b1;
                        break;
                    end
                end
                if (!ab) begin
                    ram_dout = mem[ram_addr];
                    ram_ack  = 1'b1;
                    @(posedge clk_sys); #1;
                    ram_ack  = 1'b0;
                    ack_cnt++;
                end
            end
        end
    end

    always @(negedge clk_sys) if (rand_mode) vblank = ($urandom_range(0, 3) != 0);

    // Monitor: every scoreboarded read is answered once wait is low, the cycle after the strobe at the earliest.
    initial begin
        forever begin
            @(posedge clk_sys);
            if (ioctl_rd && exp_q.size() > 0) begin
                logic [7:0] e;
                int n;
                e = exp_q.pop_front();
                n = 0;
                @(posedge clk_sys); #1;
                while (ioctl_wait && n < 3000) begin
                    stall_cnt++;
                    @(posedge clk_sys); #1;
                    n++;
                end
                checks++;
                if (ioctl_wait) begin
                    errors++;
                    $display("FAIL rd_timeout wait still high, expected data %0h", e);
                end else if (ioctl_din !== e) begin
                    errors++;
                    $display("FAIL rd_data got %0h expected %0h", ioctl_din, e);
                end
            end
        end
    end

    task automatic pulse_rd(input int a, input bit push);
        @(negedge clk_sys);
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'(a);
        if (push) exp_q.push_back(model_rd(a));
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk_sys);
        while (ioctl_wait && n < 3000) begin
            @(negedge clk_sys);
            n++;
        end
        chk("wait_release", 32'(ioctl_wait), 32'd0);
    endtask

    task automatic do_rd(input int a, input int gap);
        pulse_rd(a, 1'b1);
        wait_done();
        repeat (gap) @(negedge clk_sys);
    endtask

    task automatic session(input bit on);
        @(negedge clk_sys);
        ioctl_upload = on;
        ioctl_index  = INDEX;
        if (on) msum = 8'h00;
        repeat (3) @(negedge clk_sys);
    endtask

    task automatic wait_req();
        int n = 0;
        while (!ram_req && n < 200) begin
            @(negedge clk_sys);
            n++;
        end
        chk("req_seen", 32'(ram_req), 32'd1);
    endtask

    initial begin
        int s0, a0, bad;
        reset = 1'b1; ioctl_upload = 1'b0; ioctl_index = INDEX; ioctl_rd = 1'b0;
        ioctl_addr = '0; vblank = 1'b1; msum = 8'h00;
        for (int i = 0; i < LEN; i++) mem[(BASE + i) % LEN] = 8'(i * 3);
        repeat (3) @(negedge clk_sys);
        chk("rst_din", 32'(ioctl_din), 32'h00);
        chk("rst_wait", 32'(ioctl_wait), 32'd0);
        chk("rst_req", 32'(ram_req), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        reset = 1'b0;

        // Sequential dump, then an out-of-range read that must not touch RAM.
        session(1'b1);
        do_rd(0, 4);
        s0 = stall_cnt;
        for (int i = 1; i <= LEN; i++) do_rd(i, 4);
        chk("seq_hits_no_stall", 32'(stall_cnt - s0), 32'd0);
        a0 = ack_cnt;
        do_rd(LEN + 5, 10);
        chk("oor_no_ram", 32'(ack_cnt - a0), 32'd0);
        session(1'b0);

        // vblank gating.
        vblank = 1'b0;
        session(1'b1);
        pulse_rd(0, 1'b1);
        bad = 0;
        repeat (100) begin
            @(negedge clk_sys);
            if (ram_req || !ioctl_wait) bad++;
        end
        chk("vb_gate", 32'(bad), 32'd0);
        vblank = 1'b1;
        wait_done();
        repeat (6) @(negedge clk_sys);
        session(1'b0);

        // Out-of-order reads with a slow arbiter.
        for (int i = 0; i < LEN; i++) mem[i] = 8'($urandom);
        ack_dly = 7;
        session(1'b1);
        do_rd(5, 4);
        a0 = ack_cnt;
        s0 = stall_cnt;
        do_rd(2, 4);
        chk("r2_acks", 32'(ack_cnt - a0), 32'd2);
        chk("r2_miss", 32'(stall_cnt > s0), 32'd1);
        do_rd(5, 4);
        do_rd(LEN, 30);
        session(1'b0);

        // Session abort while a request is outstanding.
        ack_dly = 15;
        session(1'b1);
        pulse_rd(7, 1'b0);
        wait_req();
        a0 = ack_cnt;
        @(negedge clk_sys);
        ioctl_upload = 1'b0;
        bad = 0;
        for (int k = 0; k < 40 && ack_cnt == a0; k++) begin
            @(negedge clk_sys);
            if (ack_cnt == a0 && !ram_req) bad++;
        end
        chk("abort_req_held", 32'(bad), 32'd0);
        chk("abort_ack", 32'(ack_cnt - a0), 32'd1);
        chk("abort_req_low", 32'(ram_req), 32'd0);
        chk("abort_wait_low", 32'(ioctl_wait), 32'd0);
        bad = 0;
        repeat (10) begin
            @(negedge clk_sys);
            if (ram_req) bad++;
        end
        chk("abort_idle", 32'(bad), 32'd0);
        ack_dly = 0;
        session(1'b1);
        do_rd(LEN, 4);
        session(1'b0);

        // Reset in the middle of a prefetch handshake.
        ack_dly = 30;
        session(1'b1);
        do_rd(2, 0);
        wait_req();
        @(negedge clk_sys);
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        chk("mrst_req", 32'(ram_req), 32'd0);
        chk("mrst_wait", 32'(ioctl_wait), 32'd0);
        chk("mrst_din", 32'(ioctl_din), 32'h00);
        msum = 8'h00;
        ack_dly = 0;
        repeat (40) @(negedge clk_sys);
        s0 = stall_cnt;
        do_rd(3, 6);
        chk("mrst_rd3_miss", 32'(stall_cnt > s0), 32'd1);
        session(1'b0);

        // Foreign index: no RAM traffic, no stall.
        @(negedge clk_sys);
        ioctl_upload = 1'b1;
        ioctl_index  = 8'd5;
        repeat (3) @(negedge clk_sys);
        a0 = ack_cnt;
        pulse_rd(0, 1'b0);
        bad = 0;
        repeat (10) begin
            @(negedge clk_sys);
            if (ram_req || ioctl_wait) bad++;
        end
        chk("idx_quiet", 32'(bad), 32'd0);
        chk("idx_no_ram", 32'(ack_cnt - a0), 32'd0);
        session(1'b0);

        // Random reads with random vblank and arbiter latency.
        rand_mode = 1'b1;
        session(1'b1);
        for (int i = 0; i < 60; i++) begin
            int a;
            a = (i % 4 == 0) ? int'($urandom_range(0, LEN + 3)) : int'($urandom_range(0, 12));
            do_rd(a, int'($urandom_range(0, 6)));
        end
        do_rd(LEN, 4);
        rand_mode = 1'b0;
        vblank = 1'b1;
        session(1'b0);

        begin
            int n = 0;
            while (exp_q.size() > 0 && n < 5000) begin
                @(negedge clk_sys);
                n++;
            end
        end
        repeat (5) @(negedge clk_sys);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
